osd_dp_packet_arbiter: RTL and testbench
========================================

OSD_DP_PACKET_ARBITER -- requirements
Module: osd_dp_packet_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 2: number of DII requesters sharing one debug output; legal range 2..4.
REQ-002 Parameter MAX_PKT_LEN, default 12: flit limit per packet before forced release; legal range 2..255.
REQ-003 clk  input  1: single clock; all state is updated on its rising edge.
REQ-004 rst_n  input  1: reset, asynchronous assert, active-low.
REQ-005 stall  input  1: when 1, no new packet may be granted; a packet in flight continues.
REQ-006 in_flit  input  dii_flit[NUM_PORTS]: requester flits (valid, last, data[15:0]).
REQ-007 in_ready  output  NUM_PORTS: per-requester flit acceptance.
REQ-008 out_flit  output  dii_flit: registered merged flit stream.
REQ-009 out_ready  input  1: downstream acceptance of out_flit.
REQ-010 grant_id  output  $clog2(NUM_PORTS): index of the current or last granted requester.
REQ-011 busy  output  1: 1 while in state LOCKED.
REQ-012 trunc_err  output  1: one-cycle pulse on forced packet termination.

Function
REQ-013 FSM states: IDLE (no owner) and LOCKED (owner = grant_id until its last flit is accepted).
REQ-014 Input transfer: a flit is transferred from port i when in_flit[i].valid and in_ready[i] are both 1.
REQ-015 Output transfer: a flit is transferred downstream when out_flit.valid and out_ready are both 1.
REQ-016 Output register free condition: slot_free = !out_flit.valid || out_ready.
REQ-017 In IDLE with stall=0, the arbiter selects the first valid port scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_PORTS, combinationally in the same cycle.
REQ-018 In IDLE, in_ready of the selected port equals slot_free; all other in_ready are 0.
REQ-019 In IDLE with stall=1 or no valid port, all in_ready are 0 and the state is unchanged.
REQ-020 Grant: IDLE moves to LOCKED only when the first flit transfers and that flit has last=0; grant_id latches the port index.
REQ-021 Single-flit packet: a first flit with last=1 keeps the FSM in IDLE, updates grant_id and rr_ptr, and asserts no busy.
REQ-022 In LOCKED, in_ready[grant_id] = slot_free and all other in_ready are 0; stall is ignored.
REQ-023 LOCKED returns to IDLE when the owner transfers a flit with last=1; rr_ptr := grant_id.
REQ-024 Each input transfer loads out_flit with the accepted flit, and the first flit of a packet goes out 1 cycle after acceptance.
REQ-025 When slot_free=1 and no input transfers in a cycle, out_flit.valid := 0.
REQ-026 While out_ready=0, out_flit holds its value and no input transfer occurs.
REQ-027 Full throughput: with valid and out_ready held at 1, one flit moves per cycle and a new packet can be granted in the cycle after a last flit.
REQ-028 Flit counter: 8-bit flit_cnt is cleared on grant and incremented on each owner transfer.
REQ-029 Forced release: the owner transfer that makes flit_cnt = MAX_PKT_LEN without last is forwarded with last forced to 1.
REQ-030 On forced release, trunc_err pulses for 1 cycle and the FSM goes to IDLE with rr_ptr := grant_id.
REQ-031 After forced release, the owner's remaining flits compete as a new packet.
REQ-032 An owner deasserting valid mid-packet keeps LOCKED with no timeout.
REQ-033 Data is forwarded unmodified; only last may be altered, and only under REQ-029.

Reset
REQ-034 While rst_n=0: out_flit.valid=0, out_flit.last=0, out_flit.data=0, state=IDLE, busy=0, trunc_err=0, flit_cnt=0, grant_id=0, in_ready=0.
REQ-035 While rst_n=0, rr_ptr=NUM_PORTS-1, so port 0 has first priority after reset.
REQ-036 Reset asserted mid-packet discards the in-flight packet; no partial completion is issued after release.
REQ-037 Outputs become driven by the FSM from the first rising clk edge after rst_n deasserts.

Verification
REQ-038 Scenario: ports 0 and 1 both send 3-flit packets from reset -> output carries port 0 flits A0,A1,A2 then port 1 flits B0,B1,B2 with no interleaving, 6 flits in 6 consecutive cycles with out_ready=1.
REQ-039 Scenario: port 1 streams back-to-back packets while port 0 requests -> grants alternate 0,1,0,1 at packet boundaries (round-robin fairness).
REQ-040 Scenario: out_ready=0 for 4 cycles mid-packet -> out_flit stable, in_ready=0, and no flit is lost or duplicated after out_ready returns.
REQ-041 Scenario: stall=1 while IDLE with requests pending -> no grant; stall=1 during LOCKED -> packet completes; the next grant occurs only after stall=0.
REQ-042 Scenario: MAX_PKT_LEN=4 and a 6-flit packet without last -> 4th output flit has last=1, trunc_err pulses once, and the remaining 2 flits are re-arbitrated.
REQ-043 Scenario: rst_n=0 asserted after the 2nd flit of a packet -> out_flit.valid=0 immediately, busy=0, and after release the first grant goes to port 0.

Source files
------------

// File: rtl/osd_dp_packet_arbiter.sv
// ---------------------------------------------------------------------------
// osd_dp_packet_arbiter
//
// Merges NUM_PORTS debug-interconnect flit streams onto one registered output.
// Each packet is forwarded without interleaving. A packet starts with the
// first flit that a requester transfers. It ends on a flit with last=1, or
// when it has moved MAX_PKT_LEN flits, whichever comes first. When the length
// limit ends a packet, the final flit gets last=1 and trunc_err_o pulses.
// Requesters are picked by round-robin, starting after the previous owner.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   stall_i       blocks new grants; a packet already granted runs to its end
//   in_valid_i    per-port flit valid
//   in_last_i     per-port flit last marker
//   in_data_i     per-port 16-bit flit data, port p at [p*16 +: 16]
//   in_ready_o    per-port flit acceptance
//   out_valid_o   registered output flit valid
//   out_last_o    registered output flit last marker
//   out_data_o    registered output flit data
//   out_ready_i   downstream acceptance of the output flit
//   grant_id_o    index of the current or most recently granted requester
//   busy_o        high while a multi-flit packet owns the output
//   trunc_err_o   one-cycle pulse when a packet is cut at MAX_PKT_LEN
// ---------------------------------------------------------------------------
module osd_dp_packet_arbiter #(
    parameter int NUM_PORTS   = 2,
    parameter int MAX_PKT_LEN = 12
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            stall_i,
    input  logic [NUM_PORTS-1:0]            in_valid_i,
    input  logic [NUM_PORTS-1:0]            in_last_i,
    input  logic [NUM_PORTS*16-1:0]         in_data_i,
    output logic [NUM_PORTS-1:0]            in_ready_o,
    output logic                            out_valid_o,
    output logic                            out_last_o,
    output logic [15:0]                     out_data_o,
    input  logic                            out_ready_i,
    output logic [$clog2(NUM_PORTS)-1:0]    grant_id_o,
    output logic                            busy_o,
    output logic                            trunc_err_o
);

    localparam int IDW = $clog2(NUM_PORTS);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t          state_q,     state_d;
    logic [IDW-1:0]  rr_ptr_q,    rr_ptr_d;
    logic [IDW-1:0]  grant_id_q,  grant_id_d;
    logic [7:0]      flit_cnt_q,  flit_cnt_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q,  out_last_d;
    logic [15:0]     out_data_q,  out_data_d;
    logic            trunc_q,     trunc_d;
    // Goes high on the first clock edge after reset is released. Until then,
    // in_ready stays low even while the FSM sits in IDLE with requests pending.
    logic            run_q;

    // Unpack the flat data bus into one 16-bit word per port.
    logic [15:0] data_arr [NUM_PORTS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
            assign data_arr[gi] = in_data_i[gi*16 +: 16];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin pick: the first valid port after rr_ptr_q, wrapping.
    // The scan runs from the farthest offset to the nearest, so the
    // nearest valid port is the last one written and wins.
    // ------------------------------------------------------------------
    logic [IDW-1:0] sel;
    logic           sel_vld;
    int             idx;

    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        idx     = 0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            idx = (int'(rr_ptr_q) + k) % NUM_PORTS;
            if (in_valid_i[idx]) begin
                sel     = IDW'(idx);
                sel_vld = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transfer qualification
    // ------------------------------------------------------------------
    logic           slot_free;
    logic [IDW-1:0] cur_port;
    logic           port_en;
    logic           xfer;
    logic           cur_last;
    logic [15:0]    cur_data;
    logic [7:0]     cnt_inc;
    logic           forced;

    assign slot_free = !out_valid_q || out_ready_i;
    // The owner is fixed while LOCKED. In IDLE the round-robin pick is
    // offered, but only when no stall is requested.
    assign cur_port  = (state_q == ST_LOCKED) ? grant_id_q : sel;
    assign port_en   = run_q && ((state_q == ST_LOCKED) || (sel_vld && !stall_i));
    assign xfer      = port_en && slot_free && in_valid_i[cur_port];
    assign cur_last  = in_last_i[cur_port];
    assign cur_data  = data_arr[cur_port];
    assign cnt_inc   = flit_cnt_q + 8'd1;
    // The first flit of a packet is accepted in IDLE and counts as flit 1.
    // MAX_PKT_LEN is at least 2, so only a LOCKED transfer can hit the limit.
    assign forced    = (state_q == ST_LOCKED) && xfer && !cur_last &&
                       (cnt_inc == 8'(MAX_PKT_LEN));

    always_comb begin
        in_ready_o = '0;
        if (port_en && slot_free) begin
            in_ready_o[cur_port] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: FSM, counters and output register
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        flit_cnt_d  = flit_cnt_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        trunc_d     = 1'b0;

        // Output register: load on accept, drain when the downstream takes
        // the flit, otherwise hold (back-pressure).
        if (xfer) begin
            out_valid_d = 1'b1;
            out_last_d  = cur_last || forced;
            out_data_d  = cur_data;
        end else if (slot_free) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    grant_id_d = sel;
                    flit_cnt_d = 8'd1;
                    if (cur_last) begin
                        // A single-flit packet finishes right away. No lock
                        // is taken, so the port takes its turn immediately.
                        rr_ptr_d = sel;
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (xfer) begin
                    flit_cnt_d = cnt_inc;
                    if (cur_last || forced) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = grant_id_q;
                    end
                    trunc_d = forced;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= IDW'(NUM_PORTS - 1);
            grant_id_q  <= '0;
            flit_cnt_q  <= 8'd0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= 16'd0;
            trunc_q     <= 1'b0;
            run_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            flit_cnt_q  <= flit_cnt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            trunc_q     <= trunc_d;
            run_q       <= 1'b1;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_last_o  = out_last_q;
    assign out_data_o  = out_data_q;
    assign grant_id_o  = grant_id_q;
    assign busy_o      = (state_q == ST_LOCKED);
    assign trunc_err_o = trunc_q;

endmodule

// File: tb/tb_osd_dp_packet_arbiter.sv
// ---------------------------------------------------------------------------
// tb_osd_dp_packet_arbiter
//
// Directed bench for osd_dp_packet_arbiter (NUM_PORTS=2, MAX_PKT_LEN=4).
// Each port has a source queue of {last, data} flits. A flit is presented on
// the falling edge and popped when it is accepted. Every flit accepted
// downstream is logged together with its cycle number. Each test task drives
// its own stimulus and compares the log or the outputs against values
// written out by hand.
// ---------------------------------------------------------------------------
module tb_osd_dp_packet_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [1:0]  in_valid;
    logic [1:0]  in_last;
    logic [31:0] in_data;
    logic [1:0]  in_ready;
    logic        out_valid;
    logic        out_last;
    logic [15:0] out_data;
    logic        out_ready;
    logic        grant_id;
    logic        busy;
    logic        trunc_err;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int trunc_cnt = 0;

    logic [16:0] q0[$];
    logic [16:0] q1[$];
    logic [16:0] out_log[$];
    int          out_cyc[$];
    logic [16:0] h0, h1;

    always #5 clk = ~clk;

    osd_dp_packet_arbiter #(
        .NUM_PORTS   (2),
        .MAX_PKT_LEN (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_i     (stall),
        .in_valid_i  (in_valid),
        .in_last_i   (in_last),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_last_o  (out_last),
        .out_data_o  (out_data),
        .out_ready_i (out_ready),
        .grant_id_o  (grant_id),
        .busy_o      (busy),
        .trunc_err_o (trunc_err)
    );

    // Present the queue heads on the falling edge. One time unit before the
    // next rising edge, record what will transfer on that edge.
    always @(negedge clk) begin
        if (q0.size() != 0) begin
            h0 = q0[0];
            in_valid[0] = 1'b1; in_last[0] = h0[16]; in_data[15:0] = h0[15:0];
        end else begin
            in_valid[0] = 1'b0; in_last[0] = 1'b0; in_data[15:0] = 16'h0;
        end
        if (q1.size() != 0) begin
            h1 = q1[0];
            in_valid[1] = 1'b1; in_last[1] = h1[16]; in_data[31:16] = h1[15:0];
        end else begin
            in_valid[1] = 1'b0; in_last[1] = 1'b0; in_data[31:16] = 16'h0;
        end
        #4;
        if (in_valid[0] && in_ready[0] && q0.size() != 0) void'(q0.pop_front());
        if (in_valid[1] && in_ready[1] && q1.size() != 0) void'(q1.pop_front());
        if (out_valid && out_ready) begin
            out_log.push_back({out_last, out_data});
            out_cyc.push_back(cyc);
        end
        if (trunc_err) trunc_cnt++;
        cyc++;
    end

    task automatic wait_log(input int n);
        int i;
        i = 0;
        while (out_log.size() < n && i < 200) begin
            @(negedge clk);
            i++;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        out_ready = 1'b1;
        q0.delete();
        q1.delete();
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        out_log.delete();
        out_cyc.delete();
        trunc_cnt = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        out_ready = 1'b1;
        q0.push_back({1'b0, 16'h1234});
        @(negedge clk);
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests++; if (out_last !== 1'b0) begin fails++; $display("FAIL reset_out_last got %b want 0", out_last); end
        tests++; if (out_data !== 16'h0) begin fails++; $display("FAIL reset_out_data got %h want 0000", out_data); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (trunc_err !== 1'b0) begin fails++; $display("FAIL reset_trunc got %b want 0", trunc_err); end
        tests++; if (grant_id !== 1'b0) begin fails++; $display("FAIL reset_grant got %b want 0", grant_id); end
        tests++; if (in_ready !== 2'b00) begin fails++; $display("FAIL reset_in_ready got %b want 00", in_ready); end
        $display("[TB] test_reset done");
    endtask

    task automatic test_two_ports();
        logic [16:0] exp [6];
        logic [16:0] got;
        do_reset();
        exp = '{{1'b0,16'hA000}, {1'b0,16'hA001}, {1'b1,16'hA002},
                {1'b0,16'hB000}, {1'b0,16'hB001}, {1'b1,16'hB002}};
        for (int k = 0; k < 3; k++) q0.push_back(exp[k]);
        for (int k = 3; k < 6; k++) q1.push_back(exp[k]);
        wait_log(6);
        tests++; if (out_log.size() != 6) begin fails++; $display("FAIL two_ports_count got %0d want 6", out_log.size()); end
        for (int k = 0; k < 6; k++) begin
            got = (k < out_log.size()) ? out_log[k] : 17'h0;
            tests++;
            if (got !== exp[k]) begin fails++; $display("FAIL two_ports_flit%0d got %h want %h", k, got, exp[k]); end
        end
        if (out_log.size() >= 6) begin
            tests++;
            if (out_cyc[5] - out_cyc[0] != 5) begin fails++; $display("FAIL two_ports_span got %0d want 5", out_cyc[5] - out_cyc[0]); end
        end
        $display("[TB] test_two_ports done, %0d flits", out_log.size());
    endtask

    task automatic test_single();
        int i;
        do_reset();
        q1.push_back({1'b1, 16'h5A5A});
        i = 0;
        while (out_valid !== 1'b1 && i < 50) begin @(negedge clk); #1; i++; end
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_valid got %b want 1", out_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy got %b want 0", busy); end
        tests++; if (grant_id !== 1'b1) begin fails++; $display("FAIL single_grant got %b want 1", grant_id); end
        tests++; if ({out_last, out_data} !== {1'b1, 16'h5A5A}) begin fails++; $display("FAIL single_flit got %b/%h want 1/5a5a", out_last, out_data); end
        $display("[TB] test_single done");
    endtask

    task automatic test_fairness();
        int          ports [6];
        int          pkts  [6];
        logic [16:0] want;
        logic [16:0] got;
        do_reset();
        for (int p = 0; p < 4; p++) begin
            q1.push_back({1'b0, 16'hB000 | 16'(p << 4)});
            q1.push_back({1'b1, 16'hB001 | 16'(p << 4)});
        end
        for (int p = 0; p < 2; p++) begin
            q0.push_back({1'b0, 16'hA000 | 16'(p << 4)});
            q0.push_back({1'b1, 16'hA001 | 16'(p << 4)});
        end
        ports = '{0, 1, 0, 1, 1, 1};
        pkts  = '{0, 0, 1, 1, 2, 3};
        wait_log(12);
        for (int n = 0; n < 6; n++) begin
            for (int f = 0; f < 2; f++) begin
                want = {f == 1, (ports[n] == 0 ? 16'hA000 : 16'hB000) | 16'(pkts[n] << 4) | 16'(f)};
                got = (2*n+f < out_log.size()) ? out_log[2*n+f] : 17'h0;
                tests++;
                if (got !== want) begin fails++; $display("FAIL fairness_pkt%0d_flit%0d got %h want %h", n, f, got, want); end
            end
        end
        $display("[TB] test_fairness done, %0d flits", out_log.size());
    endtask

    task automatic test_backpressure();
        logic [16:0] exp [4];
        logic [16:0] got;
        do_reset();
        exp = '{{1'b0,16'hA000}, {1'b0,16'hA001}, {1'b0,16'hA002}, {1'b1,16'hA003}};
        for (int k = 0; k < 4; k++) q0.push_back(exp[k]);
        wait_log(1);
        out_ready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            #1;
            tests++; if (out_valid !== 1'b1 || out_data !== 16'hA001) begin fails++; $display("FAIL bp_hold got %b/%h want 1/a001", out_valid, out_data); end
            tests++; if (in_ready !== 2'b00) begin fails++; $display("FAIL bp_in_ready got %b want 00", in_ready); end
        end
        out_ready = 1'b1;
        wait_log(4);
        repeat (3) @(negedge clk);
        #1;
        tests++; if (out_log.size() != 4) begin fails++; $display("FAIL bp_count got %0d want 4", out_log.size()); end
        for (int k = 0; k < 4; k++) begin
            got = (k < out_log.size()) ? out_log[k] : 17'h0;
            tests++;
            if (got !== exp[k]) begin fails++; $display("FAIL bp_flit%0d got %h want %h", k, got, exp[k]); end
        end
        $display("[TB] test_backpressure done, %0d flits", out_log.size());
    endtask

    task automatic test_stall();
        int          i;
        logic [16:0] got;
        do_reset();
        stall = 1'b1;
        q0.push_back({1'b0, 16'hA000});
        q0.push_back({1'b0, 16'hA001});
        q0.push_back({1'b1, 16'hA002});
        repeat (3) @(negedge clk);
        #1;
        tests++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 2'b00 || out_log.size() != 0)
            begin fails++; $display("FAIL stall_idle got valid=%b busy=%b rdy=%b n=%0d want 0/0/00/0", out_valid, busy, in_ready, out_log.size()); end
        stall = 1'b0;
        i = 0;
        while (busy !== 1'b1 && i < 50) begin @(negedge clk); #1; i++; end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL stall_grant got busy=%b want 1", busy); end
        stall = 1'b1;
        q1.push_back({1'b0, 16'hB000});
        q1.push_back({1'b1, 16'hB001});
        wait_log(3);
        repeat (3) @(negedge clk);
        #1;
        tests++; if (out_log.size() != 3 || in_ready !== 2'b00 || busy !== 1'b0)
            begin fails++; $display("FAIL stall_locked got n=%0d rdy=%b busy=%b want 3/00/0", out_log.size(), in_ready, busy); end
        got = (out_log.size() >= 3) ? out_log[2] : 17'h0;
        tests++; if (got !== {1'b1, 16'hA002}) begin fails++; $display("FAIL stall_last got %h want 1a002", got); end
        stall = 1'b0;
        wait_log(5);
        got = (out_log.size() >= 5) ? out_log[3] : 17'h0;
        tests++; if (got !== {1'b0, 16'hB000}) begin fails++; $display("FAIL stall_next0 got %h want 0b000", got); end
        got = (out_log.size() >= 5) ? out_log[4] : 17'h0;
        tests++; if (got !== {1'b1, 16'hB001}) begin fails++; $display("FAIL stall_next1 got %h want 1b001", got); end
        $display("[TB] test_stall done, %0d flits", out_log.size());
    endtask

    task automatic test_trunc();
        logic [16:0] exp [6];
        logic [16:0] got;
        do_reset();
        for (int k = 0; k < 6; k++) q0.push_back({k == 5, 16'hA000 | 16'(k)});
        // The 4th flit carries a forced last. The last two flits form a new packet.
        exp = '{{1'b0,16'hA000}, {1'b0,16'hA001}, {1'b0,16'hA002},
                {1'b1,16'hA003}, {1'b0,16'hA004}, {1'b1,16'hA005}};
        wait_log(6);
        repeat (2) @(negedge clk);
        #1;
        for (int k = 0; k < 6; k++) begin
            got = (k < out_log.size()) ? out_log[k] : 17'h0;
            tests++;
            if (got !== exp[k]) begin fails++; $display("FAIL trunc_flit%0d got %h want %h", k, got, exp[k]); end
        end
        tests++; if (trunc_cnt != 1) begin fails++; $display("FAIL trunc_pulses got %0d want 1", trunc_cnt); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL trunc_busy_end got %b want 0", busy); end
        $display("[TB] test_trunc done, %0d flits, %0d pulses", out_log.size(), trunc_cnt);
    endtask

    task automatic test_reset_mid();
        logic [16:0] exp [4];
        logic [16:0] got;
        do_reset();
        for (int k = 0; k < 4; k++) q0.push_back({k == 3, 16'hA000 | 16'(k)});
        q1.push_back({1'b0, 16'hB000});
        q1.push_back({1'b1, 16'hB001});
        wait_log(1);
        rst_n = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 2'b00)
            begin fails++; $display("FAIL rstmid_now got valid=%b busy=%b rdy=%b want 0/0/00", out_valid, busy, in_ready); end
        q0.delete();
        q1.delete();
        q1.push_back({1'b0, 16'hB000});
        q1.push_back({1'b1, 16'hB001});
        q0.push_back({1'b0, 16'hC000});
        q0.push_back({1'b1, 16'hC001});
        repeat (2) @(negedge clk);
        #1;
        out_log.delete();
        out_cyc.delete();
        rst_n = 1'b1;
        exp = '{{1'b0,16'hC000}, {1'b1,16'hC001}, {1'b0,16'hB000}, {1'b1,16'hB001}};
        wait_log(4);
        for (int k = 0; k < 4; k++) begin
            got = (k < out_log.size()) ? out_log[k] : 17'h0;
            tests++;
            if (got !== exp[k]) begin fails++; $display("FAIL rstmid_flit%0d got %h want %h", k, got, exp[k]); end
        end
        $display("[TB] test_reset_mid done, %0d flits", out_log.size());
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        out_ready = 1'b1;
        in_valid = 2'b00;
        in_last = 2'b00;
        in_data = 32'h0;
        test_reset();
        test_two_ports();
        test_single();
        test_fairness();
        test_backpressure();
        test_stall();
        test_trunc();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
